reg_rename_file: RTL and testbench
==================================

Name: reg_rename_file

Overview:
- Parametrised successor to the architectural register/status file.
- Holds architectural register values, per-register busy flags and ROB-tag dependencies.
- Serves N decoder read ports with ROB forwarding and accepts C commits per cycle.
- Adds branch checkpoints, so a mispredict restores the rename state in one cycle instead of a full flush.
- Sits between decoder, reorder buffer and branch unit.

Parameters:
- XLEN, 32, data width.
- REG_COUNT, 32, number of architectural registers; REG_W = clog2(REG_COUNT).
- ROB_W, 4, ROB tag width.
- RD_PORTS, 2, decoder read ports.
- CM_PORTS, 2, commit ports; port 0 is oldest.
- CKPTS, 4, checkpoint slots; CK_W = clog2(CKPTS).

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset; asynchronous, active-high
- rdy_in  in  1  global stall; when low, no state changes except reset
- flush  in  1  full pipeline flush
- rd_reg_id  in  RD_PORTS*REG_W  decoder read register ids, port p at slice p
- rd_data  out  RD_PORTS*XLEN  operand value
- rd_pending  out  RD_PORTS  operand not yet available
- rd_dep  out  RD_PORTS*ROB_W  ROB tag producing the operand
- rob_q_id  out  RD_PORTS*ROB_W  tag query to ROB, equals rd_dep
- rob_q_ready  in  RD_PORTS  ROB has a value for the queried tag
- rob_q_data  in  RD_PORTS*XLEN  ROB value for the queried tag
- cm_reg_id  in  CM_PORTS*REG_W  commit destination; 0 = no commit
- cm_data  in  CM_PORTS*XLEN  commit value
- cm_rob_id  in  CM_PORTS*ROB_W  committing tag
- mk_reg_id  in  REG_W  rename mark destination; 0 = none
- mk_rob_id  in  ROB_W  tag assigned to the mark
- ck_save  in  1  take a checkpoint
- ck_save_id  in  CK_W  slot to write
- ck_restore  in  1  restore a checkpoint (mispredict)
- ck_free  in  1  release a slot (branch resolved correct)
- ck_id  in  CK_W  slot for restore/free
- ck_valid  out  CKPTS  slot-occupied vector, registered
- ck_err  out  1  one-cycle pulse: restore/free aimed at an invalid slot

Behaviour:
- Reset (async, any time, including mid-restore): data, busy and tag arrays clear to 0; all ck_valid clear to 0; ck_err clears to 0. Reads then return data 0, pending 0, dep 0.
- Read path is combinational from current state. For each port p:
  - dep = tag[id].
  - data = busy ? rob_q_data[p] : data[id].
  - pending = busy & ~rob_q_ready[p].
- Register 0: reads 0 and not busy; commits and marks to register 0 are ignored.
- Same-cycle commit, mark or restore is not bypassed to the read path; it is visible the next cycle.
- Priority, all gated by rdy_in except reset: flush > restore > normal.
- Flush: clears all busy and tags and all ck_valid; data is retained. Save, restore and free in the same cycle are ignored.
- Commit (normal and restore cycles):
  - Each port with nonzero id writes data[id].
  - If two ports target the same register, the higher port index wins the data write.
  - Busy clears when tag[id] == cm_rob_id on any port, unless mk_reg_id == id this cycle.
  - The same tag-match clear also applies to every valid checkpoint's copy, so restored state never waits on a retired tag.
- Mark (normal cycle only): busy[mk] <= 1 and tag[mk] <= mk_rob_id. Mark wins over a commit clear on the same register.
- Save (normal cycle): slot ck_save_id captures the post-update busy/tag vectors (this cycle's commits and mark included) and sets ck_valid. Saving to an occupied slot overwrites it.
- Restore: if ck_valid[ck_id] is set:
  - Live busy/tag <= snapshot, with this cycle's commit clears applied.
  - ck_valid[ck_id] <= 0.
  - Same-cycle mark and save are dropped.
  - Other slots are untouched; the branch unit frees younger slots itself.
- Restore or free on an invalid slot: no state change, ck_err = 1 for the next cycle.
- Free: ck_valid[ck_id] <= 0. Free and save on the same slot in one cycle: save wins.
- rdy_in low: every state and ck_err hold. Requests presented while rdy_in is low are lost.

Test Plan:
- Reset, then read x5 on both ports -> data 0, pending 0, dep 0; ck_valid = 0.
- Mark x5 tag 3; next cycle read x5 with rob_q_ready=0 -> pending 1, dep 3. Set rob_q_ready=1, rob_q_data=0xAB -> data 0xAB, pending 0.
- Commit x5 tag 3 data 0x11 with mark x5 tag 7 in the same cycle -> data[5]=0x11, busy stays, dep 7. Dual-port commit to x6 with 0x1 and 0x2 -> data[6]=0x2.
- Mark x7 tag 2, save slot 1, mark x7 tag 9, commit tag 2, restore slot 1 -> x7 not busy, ck_valid[1]=0.
- Restore slot 2 while ck_valid=0 -> ck_err pulses 1 for exactly one cycle, state unchanged. Flush with 3 slots valid -> all busy clear, ck_valid=0, data retained.
- Assert rst_in asynchronously between clock edges during a restore -> all outputs zero immediately. With rdy_in=0, a mark is ignored.

Source files
------------

// File: rtl/reg_rename_file.sv
// Architectural register file with busy/ROB-tag rename state, ROB-forwarded
// read ports, multi-port commit and branch checkpoints with one-cycle restore.
module reg_rename_file #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int ROB_W     = 4,
  parameter int RD_PORTS  = 2,
  parameter int CM_PORTS  = 2,
  parameter int CKPTS     = 4,
  localparam int REG_W    = $clog2(REG_COUNT),
  localparam int CK_W     = $clog2(CKPTS)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush,
  input  logic [RD_PORTS*REG_W-1:0]    rd_reg_id,
  output logic [RD_PORTS*XLEN-1:0]     rd_data,
  output logic [RD_PORTS-1:0]          rd_pending,
  output logic [RD_PORTS*ROB_W-1:0]    rd_dep,
  output logic [RD_PORTS*ROB_W-1:0]    rob_q_id,
  input  logic [RD_PORTS-1:0]          rob_q_ready,
  input  logic [RD_PORTS*XLEN-1:0]     rob_q_data,
  input  logic [CM_PORTS*REG_W-1:0]    cm_reg_id,
  input  logic [CM_PORTS*XLEN-1:0]     cm_data,
  input  logic [CM_PORTS*ROB_W-1:0]    cm_rob_id,
  input  logic [REG_W-1:0]             mk_reg_id,
  input  logic [ROB_W-1:0]             mk_rob_id,
  input  logic                         ck_save,
  input  logic [CK_W-1:0]              ck_save_id,
  input  logic                         ck_restore,
  input  logic                         ck_free,
  input  logic [CK_W-1:0]              ck_id,
  output logic [CKPTS-1:0]             ck_valid,
  output logic                         ck_err
);

  typedef logic [REG_COUNT-1:0]            busy_vec_t;
  typedef logic [REG_COUNT-1:0][ROB_W-1:0] tag_vec_t;

  logic [XLEN-1:0] data_q [REG_COUNT];
  logic [XLEN-1:0] data_d [REG_COUNT];
  busy_vec_t       busy_q, busy_d;
  tag_vec_t        tag_q, tag_d;
  busy_vec_t       ck_busy_q [CKPTS];
  busy_vec_t       ck_busy_d [CKPTS];
  tag_vec_t        ck_tag_q  [CKPTS];
  tag_vec_t        ck_tag_d  [CKPTS];
  logic [CKPTS-1:0] ck_valid_q, ck_valid_d;
  logic            ck_err_q, ck_err_d;

  logic            restore_hit;
  logic            mark_en;

  assign restore_hit = ck_restore && ck_valid_q[ck_id];
  assign mark_en     = !ck_restore && (mk_reg_id != '0);

  // Register 0 is never written, so it always reads as value 0, not busy.
  always_comb begin
    rd_data    = '0;
    rd_pending = '0;
    rd_dep     = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_dep[p*ROB_W +: ROB_W] = tag_q[rd_reg_id[p*REG_W +: REG_W]];
      rd_data[p*XLEN +: XLEN]  = busy_q[rd_reg_id[p*REG_W +: REG_W]]
                                 ? rob_q_data[p*XLEN +: XLEN]
                                 : data_q[rd_reg_id[p*REG_W +: REG_W]];
      rd_pending[p] = busy_q[rd_reg_id[p*REG_W +: REG_W]] & ~rob_q_ready[p];
    end
  end

  assign rob_q_id = rd_dep;
  assign ck_valid = ck_valid_q;
  assign ck_err   = ck_err_q;

  // NOTE: every next-state variable is defaulted to its current value first,
  // so no path through this block leaves one unassigned and infers a latch.
  always_comb begin
    data_d     = data_q;
    busy_d     = busy_q;
    tag_d      = tag_q;
    ck_busy_d  = ck_busy_q;
    ck_tag_d   = ck_tag_q;
    ck_valid_d = ck_valid_q;
    ck_err_d   = ck_err_q;
    if (rdy_in) begin
      ck_err_d = 1'b0;
      if (flush) begin
        busy_d     = '0;
        tag_d      = '0;
        ck_valid_d = '0;
      end else begin
        if (restore_hit) begin
          busy_d             = ck_busy_q[ck_id];
          tag_d              = ck_tag_q[ck_id];
          ck_valid_d[ck_id]  = 1'b0;
        end
        // Higher ports are processed later, so they win same-register data writes.
        for (int c = 0; c < CM_PORTS; c++) begin
          if (cm_reg_id[c*REG_W +: REG_W] != '0) begin
            data_d[cm_reg_id[c*REG_W +: REG_W]] = cm_data[c*XLEN +: XLEN];
            if (tag_d[cm_reg_id[c*REG_W +: REG_W]] == cm_rob_id[c*ROB_W +: ROB_W] &&
                !(mark_en && mk_reg_id == cm_reg_id[c*REG_W +: REG_W]))
              busy_d[cm_reg_id[c*REG_W +: REG_W]] = 1'b0;
            for (int k = 0; k < CKPTS; k++) begin
              if (ck_valid_q[k] &&
                  ck_tag_q[k][cm_reg_id[c*REG_W +: REG_W]] == cm_rob_id[c*ROB_W +: ROB_W])
                ck_busy_d[k][cm_reg_id[c*REG_W +: REG_W]] = 1'b0;
            end
          end
        end
        if (ck_restore) begin
          if (!ck_valid_q[ck_id]) ck_err_d = 1'b1;
        end else begin
          if (mark_en) begin
            busy_d[mk_reg_id] = 1'b1;
            tag_d[mk_reg_id]  = mk_rob_id;
          end
          if (ck_free) begin
            if (ck_valid_q[ck_id]) ck_valid_d[ck_id] = 1'b0;
            else                   ck_err_d          = 1'b1;
          end
          // Save comes after free so a save to the freed slot wins.
          if (ck_save) begin
            ck_busy_d[ck_save_id]  = busy_d;
            ck_tag_d[ck_save_id]   = tag_d;
            ck_valid_d[ck_save_id] = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      // NOTE: the data array is reset here because reads of unwritten
      // registers must return 0; a plain RAM array would normally not be.
      data_q     <= '{default: '0};
      busy_q     <= '0;
      tag_q      <= '0;
      ck_busy_q  <= '{default: '0};
      ck_tag_q   <= '{default: '0};
      ck_valid_q <= '0;
      ck_err_q   <= 1'b0;
    end else begin
      data_q     <= data_d;
      busy_q     <= busy_d;
      tag_q      <= tag_d;
      ck_busy_q  <= ck_busy_d;
      ck_tag_q   <= ck_tag_d;
      ck_valid_q <= ck_valid_d;
      ck_err_q   <= ck_err_d;
    end
  end

endmodule

// File: tb/tb_reg_rename_file.sv
// Self-checking bench for reg_rename_file: directed scenarios with literal
// expectations, then randomized traffic against an array-based reference model.
module tb_reg_rename_file;
  localparam int XLEN = 32, REG_COUNT = 32, ROB_W = 4;
  localparam int RD_PORTS = 2, CM_PORTS = 2, CKPTS = 4;
  localparam int REG_W = 5, CK_W = 2;

  logic                      clk_in, rst_in, rdy_in, flush;
  logic [RD_PORTS*REG_W-1:0] rd_reg_id;
  logic [RD_PORTS*XLEN-1:0]  rd_data;
  logic [RD_PORTS-1:0]       rd_pending;
  logic [RD_PORTS*ROB_W-1:0] rd_dep, rob_q_id;
  logic [RD_PORTS-1:0]       rob_q_ready;
  logic [RD_PORTS*XLEN-1:0]  rob_q_data;
  logic [CM_PORTS*REG_W-1:0] cm_reg_id;
  logic [CM_PORTS*XLEN-1:0]  cm_data;
  logic [CM_PORTS*ROB_W-1:0] cm_rob_id;
  logic [REG_W-1:0]          mk_reg_id;
  logic [ROB_W-1:0]          mk_rob_id;
  logic                      ck_save, ck_restore, ck_free;
  logic [CK_W-1:0]           ck_save_id, ck_id;
  logic [CKPTS-1:0]          ck_valid;
  logic                      ck_err;

  // Per-port stimulus, packed onto the flat DUT buses below.
  logic [REG_W-1:0] in_rd_id   [RD_PORTS];
  logic             in_rq_rdy  [RD_PORTS];
  logic [XLEN-1:0]  in_rq_data [RD_PORTS];
  logic [REG_W-1:0] in_cm_id   [CM_PORTS];
  logic [XLEN-1:0]  in_cm_data [CM_PORTS];
  logic [ROB_W-1:0] in_cm_rob  [CM_PORTS];

  always_comb begin
    rd_reg_id = '0; rob_q_ready = '0; rob_q_data = '0;
    cm_reg_id = '0; cm_data = '0; cm_rob_id = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_reg_id[p*REG_W +: REG_W] = in_rd_id[p];
      rob_q_ready[p]              = in_rq_rdy[p];
      rob_q_data[p*XLEN +: XLEN]  = in_rq_data[p];
    end
    for (int c = 0; c < CM_PORTS; c++) begin
      cm_reg_id[c*REG_W +: REG_W] = in_cm_id[c];
      cm_data[c*XLEN +: XLEN]     = in_cm_data[c];
      cm_rob_id[c*ROB_W +: ROB_W] = in_cm_rob[c];
    end
  end

  reg_rename_file #(
    .XLEN(XLEN), .REG_COUNT(REG_COUNT), .ROB_W(ROB_W),
    .RD_PORTS(RD_PORTS), .CM_PORTS(CM_PORTS), .CKPTS(CKPTS)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .rd_reg_id(rd_reg_id), .rd_data(rd_data), .rd_pending(rd_pending),
    .rd_dep(rd_dep), .rob_q_id(rob_q_id), .rob_q_ready(rob_q_ready),
    .rob_q_data(rob_q_data), .cm_reg_id(cm_reg_id), .cm_data(cm_data),
    .cm_rob_id(cm_rob_id), .mk_reg_id(mk_reg_id), .mk_rob_id(mk_rob_id),
    .ck_save(ck_save), .ck_save_id(ck_save_id), .ck_restore(ck_restore),
    .ck_free(ck_free), .ck_id(ck_id), .ck_valid(ck_valid), .ck_err(ck_err)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: plain arrays updated rule by rule each clock edge.
  logic [XLEN-1:0]  m_data [REG_COUNT];
  logic             m_busy [REG_COUNT];
  logic [ROB_W-1:0] m_tag  [REG_COUNT];
  logic             m_ckv  [CKPTS];
  logic             m_ckb  [CKPTS][REG_COUNT];
  logic [ROB_W-1:0] m_ckt  [CKPTS][REG_COUNT];
  logic             m_err;

  function automatic void model_reset();
    for (int r = 0; r < REG_COUNT; r++) begin
      m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
    end
    for (int k = 0; k < CKPTS; k++) begin
      m_ckv[k] = 1'b0;
      for (int r = 0; r < REG_COUNT; r++) begin
        m_ckb[k][r] = 1'b0; m_ckt[k][r] = '0;
      end
    end
    m_err = 1'b0;
  endfunction

  function automatic void model_step();
    bit hit;
    int r;
    if (rst_in) begin model_reset(); return; end
    if (!rdy_in) return;
    m_err = 1'b0;
    if (flush) begin
      for (int i = 0; i < REG_COUNT; i++) begin m_busy[i] = 1'b0; m_tag[i] = '0; end
      for (int k = 0; k < CKPTS; k++) m_ckv[k] = 1'b0;
      return;
    end
    hit = ck_restore && m_ckv[ck_id];
    if (hit) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        m_busy[i] = m_ckb[ck_id][i]; m_tag[i] = m_ckt[ck_id][i];
      end
      m_ckv[ck_id] = 1'b0;
    end
    for (int c = 0; c < CM_PORTS; c++) begin
      r = int'(in_cm_id[c]);
      if (r != 0) begin
        m_data[r] = in_cm_data[c];
        if (m_tag[r] == in_cm_rob[c] && !(!ck_restore && int'(mk_reg_id) == r))
          m_busy[r] = 1'b0;
        for (int k = 0; k < CKPTS; k++)
          if (m_ckv[k] && m_ckt[k][r] == in_cm_rob[c]) m_ckb[k][r] = 1'b0;
      end
    end
    if (ck_restore) begin
      if (!hit) m_err = 1'b1;
    end else begin
      if (mk_reg_id != 0) begin m_busy[mk_reg_id] = 1'b1; m_tag[mk_reg_id] = mk_rob_id; end
      if (ck_free) begin
        if (m_ckv[ck_id]) m_ckv[ck_id] = 1'b0;
        else              m_err        = 1'b1;
      end
      if (ck_save) begin
        for (int i = 0; i < REG_COUNT; i++) begin
          m_ckb[ck_save_id][i] = m_busy[i]; m_ckt[ck_save_id][i] = m_tag[i];
        end
        m_ckv[ck_save_id] = 1'b1;
      end
    end
  endfunction

  // Compare process: outputs are combinational from state and inputs, so
  // they are sampled mid-cycle against the model.
  always @(negedge clk_in) begin
    if (chk_en) begin
      logic [CKPTS-1:0] v;
      for (int p = 0; p < RD_PORTS; p++) begin
        logic [REG_W-1:0] id;
        id = in_rd_id[p];
        check($sformatf("rd_dep[%0d]", p), 64'(rd_dep[p*ROB_W +: ROB_W]), 64'(m_tag[id]));
        check($sformatf("rob_q_id[%0d]", p), 64'(rob_q_id[p*ROB_W +: ROB_W]), 64'(m_tag[id]));
        check($sformatf("rd_data[%0d]", p), 64'(rd_data[p*XLEN +: XLEN]),
              64'(m_busy[id] ? in_rq_data[p] : m_data[id]));
        check($sformatf("rd_pending[%0d]", p), 64'(rd_pending[p]),
              64'(m_busy[id] && !in_rq_rdy[p]));
      end
      for (int k = 0; k < CKPTS; k++) v[k] = m_ckv[k];
      check("ck_valid", 64'(ck_valid), 64'(v));
      check("ck_err", 64'(ck_err), 64'(m_err));
    end
  end

  task automatic clear_inputs();
    rdy_in = 1'b1; flush = 1'b0;
    mk_reg_id = '0; mk_rob_id = '0;
    ck_save = 1'b0; ck_restore = 1'b0; ck_free = 1'b0;
    ck_save_id = '0; ck_id = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      in_rd_id[p] = '0; in_rq_rdy[p] = 1'b0; in_rq_data[p] = '0;
    end
    for (int c = 0; c < CM_PORTS; c++) begin
      in_cm_id[c] = '0; in_cm_data[c] = '0; in_cm_rob[c] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic read_ports(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    in_rd_id[0] = a; in_rd_id[1] = b;
    in_rq_rdy[0] = 1'b0; in_rq_rdy[1] = 1'b0;
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_in = 1'b0;
    model_reset();
    #1 rst_in = 1'b1;
    chk_en = 1'b1;
    tick(); tick();
    rst_in = 1'b0;

    // Reset state.
    read_ports(5'd5, 5'd5);
    check("rst data0", 64'(rd_data[31:0]), 64'h0);
    check("rst pend0", 64'(rd_pending[0]), 64'h0);
    check("rst dep1", 64'(rd_dep[7:4]), 64'h0);
    check("rst ck_valid", 64'(ck_valid), 64'h0);

    // Mark x5 tag 3, then forward from the ROB.
    mk_reg_id = 5'd5; mk_rob_id = 4'd3; tick(); clear_inputs();
    read_ports(5'd5, 5'd5);
    check("mark pend", 64'(rd_pending[0]), 64'h1);
    check("mark dep", 64'(rd_dep[3:0]), 64'h3);
    in_rq_rdy[0] = 1'b1; in_rq_data[0] = 32'hAB; #1;
    check("fwd data", 64'(rd_data[31:0]), 64'hAB);
    check("fwd pend", 64'(rd_pending[0]), 64'h0);

    // Commit x5 tag 3 while re-marking x5 tag 7; dual commit to x6.
    in_cm_id[0] = 5'd5; in_cm_rob[0] = 4'd3; in_cm_data[0] = 32'h11;
    mk_reg_id = 5'd5; mk_rob_id = 4'd7; tick(); clear_inputs();
    read_ports(5'd5, 5'd5);
    check("mark>clear pend", 64'(rd_pending[0]), 64'h1);
    check("mark>clear dep", 64'(rd_dep[3:0]), 64'h7);
    in_cm_id[0] = 5'd6; in_cm_data[0] = 32'h1;
    in_cm_id[1] = 5'd6; in_cm_data[1] = 32'h2; tick(); clear_inputs();
    read_ports(5'd6, 5'd6);
    check("dual commit", 64'(rd_data[63:32]), 64'h2);

    // Checkpoint, re-mark, retire old tag, restore.
    mk_reg_id = 5'd7; mk_rob_id = 4'd2; tick(); clear_inputs();
    ck_save = 1'b1; ck_save_id = 2'd1; tick(); clear_inputs();
    #1 check("save valid", 64'(ck_valid), 64'h2);
    mk_reg_id = 5'd7; mk_rob_id = 4'd9; tick(); clear_inputs();
    in_cm_id[0] = 5'd7; in_cm_rob[0] = 4'd2; in_cm_data[0] = 32'h77; tick(); clear_inputs();
    ck_restore = 1'b1; ck_id = 2'd1; tick(); clear_inputs();
    read_ports(5'd7, 5'd7);
    check("restore pend", 64'(rd_pending[0]), 64'h0);
    check("restore data", 64'(rd_data[31:0]), 64'h77);
    check("restore dep", 64'(rd_dep[3:0]), 64'h2);
    check("restore valid", 64'(ck_valid), 64'h0);

    // Restore to an empty slot.
    ck_restore = 1'b1; ck_id = 2'd2; tick(); clear_inputs();
    #1 check("err pulse", 64'(ck_err), 64'h1);
    tick();
    check("err drop", 64'(ck_err), 64'h0);

    // Flush with three valid slots.
    mk_reg_id = 5'd5; mk_rob_id = 4'd4; tick(); clear_inputs();
    for (int k = 0; k < 3; k++) begin
      ck_save = 1'b1; ck_save_id = CK_W'(k); tick(); clear_inputs();
    end
    #1 check("three valid", 64'(ck_valid), 64'h7);
    flush = 1'b1; tick(); clear_inputs();
    read_ports(5'd5, 5'd6);
    check("flush data5", 64'(rd_data[31:0]), 64'h11);
    check("flush data6", 64'(rd_data[63:32]), 64'h2);
    check("flush pend", 64'(rd_pending), 64'h0);
    check("flush dep", 64'(rd_dep), 64'h0);
    check("flush valid", 64'(ck_valid), 64'h0);

    // Asynchronous reset in the middle of a restore cycle.
    mk_reg_id = 5'd9; mk_rob_id = 4'd5; tick(); clear_inputs();
    ck_save = 1'b1; ck_save_id = 2'd3; tick(); clear_inputs();
    ck_restore = 1'b1; ck_id = 2'd3; in_rd_id[0] = 5'd9; in_rd_id[1] = 5'd6;
    in_rq_data[0] = 32'h55;
    #2 rst_in = 1'b1;
    model_reset();
    #1;
    check("arst data0", 64'(rd_data[31:0]), 64'h0);
    check("arst data1", 64'(rd_data[63:32]), 64'h0);
    check("arst pend", 64'(rd_pending), 64'h0);
    check("arst dep", 64'(rd_dep), 64'h0);
    check("arst valid", 64'(ck_valid), 64'h0);
    tick();
    rst_in = 1'b0; clear_inputs();

    // Stalled mark is lost.
    rdy_in = 1'b0; mk_reg_id = 5'd9; mk_rob_id = 4'd6; tick(); clear_inputs();
    read_ports(5'd9, 5'd9);
    check("stall pend", 64'(rd_pending[0]), 64'h0);
    check("stall dep", 64'(rd_dep[3:0]), 64'h0);

    // Randomized traffic over a small register window to force collisions.
    for (int i = 0; i < 3000; i++) begin
      rdy_in     = ($urandom_range(0, 9) != 0);
      flush      = ($urandom_range(0, 39) == 0);
      ck_restore = ($urandom_range(0, 9) == 0);
      ck_free    = ($urandom_range(0, 9) == 0);
      ck_save    = ($urandom_range(0, 4) == 0);
      ck_id      = CK_W'($urandom_range(0, CKPTS-1));
      ck_save_id = CK_W'($urandom_range(0, CKPTS-1));
      mk_reg_id  = ($urandom_range(0, 2) == 0) ? '0 : REG_W'($urandom_range(0, 7));
      mk_rob_id  = ROB_W'($urandom_range(0, 15));
      for (int c = 0; c < CM_PORTS; c++) begin
        in_cm_id[c]   = ($urandom_range(0, 1) == 0) ? '0 : REG_W'($urandom_range(0, 7));
        in_cm_data[c] = $urandom;
        in_cm_rob[c]  = ($urandom_range(0, 1) == 0) ? m_tag[in_cm_id[c]]
                                                    : ROB_W'($urandom_range(0, 15));
      end
      for (int p = 0; p < RD_PORTS; p++) begin
        in_rd_id[p]   = REG_W'($urandom_range(0, 7));
        in_rq_rdy[p]  = 1'($urandom_range(0, 1));
        in_rq_data[p] = $urandom;
      end
      tick();
    end

    clear_inputs();
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
